// File: rtl/data_memory_wait.sv
// rtl/data_memory_wait.sv - wait-state data memory with request/response handshake
// Optional per-byte write enables when DMEM_BYTE_EN_EN is defined.
module data_memory_wait #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   write_data,
`ifdef DMEM_BYTE_EN_EN
  input  logic [DATA_WIDTH/8-1:0] write_mask,
`endif
  output logic                    resp_valid,
  output logic                    resp_err,
  output logic [DATA_WIDTH-1:0]   read_data
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [3:0]              r_wait_cnt;
  logic                    r_write;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [NB-1:0]           r_mask;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic                    w_accept;
  logic                    w_done;
  logic                    w_in_range;
  logic [IDX_W-1:0]        w_idx;
  logic [NB-1:0]           w_mask_in;

`ifdef DMEM_BYTE_EN_EN
  assign w_mask_in = write_mask;
`else
  assign w_mask_in = '1;
`endif

  // Full-width compare so addresses beyond DEPTH never alias onto low words.
  assign w_in_range = ({1'b0, r_addr} < DEPTH_EXT);
  assign w_idx      = r_addr[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    w_accept     = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept     = 1'b1;
          w_state_next = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        if (r_wait_cnt == 4'd0) w_state_next = S_ACCESS;
      end
      S_ACCESS: begin
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= 4'd0;
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_mask     <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      read_data  <= '0;
    end else begin
      resp_valid <= w_done;
      resp_err   <= w_done && !w_in_range;
      if (w_accept) begin
        r_write    <= req_write;
        r_addr     <= address;
        r_wdata    <= write_data;
        r_mask     <= w_mask_in;
        r_wait_cnt <= WAIT_LOAD;
      end else if (r_state == S_WAIT && r_wait_cnt != 4'd0) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end
      if (w_done && !r_write) read_data <= w_in_range ? r_mem[w_idx] : '0;
    end
  end

  // Storage is never cleared; a reset landing on the ACCESS edge cancels the write.
  always_ff @(posedge clk) begin
    if (!rst && w_done && r_write && w_in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (r_mask[b]) r_mem[w_idx][b*8 +: 8] <= r_wdata[b*8 +: 8];
      end
    end
  end
endmodule

// File: tb/tb_data_memory_wait.sv
// tb/tb_data_memory_wait.sv - randomized self-checking bench for data_memory_wait
module tb_data_memory_wait;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic [15:0] address    [2];
  logic [15:0] write_data [2];
  logic        resp_valid [2];
  logic        resp_err   [2];
  logic [15:0] read_data  [2];
`ifdef DMEM_BYTE_EN_EN
  logic [1:0]  write_mask [2];
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [15:0] ref_mem [2][256];
  logic [15:0] last_rd [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_memory_wait #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .address(address[0]), .write_data(write_data[0]),
`ifdef DMEM_BYTE_EN_EN
    .write_mask(write_mask[0]),
`endif
    .resp_valid(resp_valid[0]), .resp_err(resp_err[0]), .read_data(read_data[0])
  );

  data_memory_wait #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .address(address[1]), .write_data(write_data[1]),
`ifdef DMEM_BYTE_EN_EN
    .write_mask(write_mask[1]),
`endif
    .resp_valid(resp_valid[1]), .resp_err(resp_err[1]), .read_data(read_data[1])
  );

  function automatic int wc(input int u);
    return (u == 0) ? 2 : 0;
  endfunction

  // Model update: one access of the abstract memory, applied only when in range.
  function automatic void model_access(input int u, input bit wr, input logic [15:0] addr,
                                       input logic [15:0] data, input logic [1:0] mask);
    if (addr >= 16'd256) begin
      if (!wr) last_rd[u] = 16'h0000;
    end else if (wr) begin
      if (mask[0]) ref_mem[u][addr[7:0]][7:0]  = data[7:0];
      if (mask[1]) ref_mem[u][addr[7:0]][15:8] = data[15:8];
    end else begin
      last_rd[u] = ref_mem[u][addr[7:0]];
    end
  endfunction

  // Drives one request starting just after a negedge with the unit idle; returns what it saw.
  // Junk requests are presented while busy and must be ignored.
  task automatic do_req(input int u, input bit wr, input logic [15:0] addr, input logic [15:0] data,
                        output int lat, output logic [15:0] rd, output logic err,
                        output int bad, output int acc_cyc);
    int w;
    w = wc(u);
    bad = 0; lat = -1; rd = 16'h0; err = 1'b0;
    if (req_ready[u] !== 1'b1) bad++;
    req_valid[u] = 1'b1; req_write[u] = wr; address[u] = addr; write_data[u] = data;
    @(negedge clk);
    acc_cyc = cyc;
    for (int k = 1; k <= w + 4 && lat < 0; k++) begin
      req_valid[u] = 1'($urandom); req_write[u] = 1'($urandom);
      address[u] = 16'($urandom_range(0, 15)); write_data[u] = 16'($urandom);
`ifdef DMEM_BYTE_EN_EN
      write_mask[u] = 2'($urandom);
`endif
      @(negedge clk);
      if (resp_valid[u] === 1'b1) begin
        lat = k; rd = read_data[u]; err = resp_err[u];
        if (req_ready[u] !== 1'b1) bad++;
      end else begin
        if (resp_err[u] !== 1'b0) bad++;
        if (req_ready[u] !== 1'b0) bad++;
      end
    end
    req_valid[u] = 1'b0;
  endtask

  task automatic test_reset();
    int seen;
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 1'b0; req_write[u] = 1'b0; address[u] = '0; write_data[u] = '0;
`ifdef DMEM_BYTE_EN_EN
      write_mask[u] = 2'b11;
`endif
      last_rd[u] = 16'h0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      n_cmp++; if (req_ready[u] !== 1'b1) begin n_bad++; $display("FAIL reset_ready u%0d: got %b expected 1", u, req_ready[u]); end
      n_cmp++; if (resp_valid[u] !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid u%0d: got %b expected 0", u, resp_valid[u]); end
      n_cmp++; if (resp_err[u] !== 1'b0) begin n_bad++; $display("FAIL reset_resp_err u%0d: got %b expected 0", u, resp_err[u]); end
      n_cmp++; if (read_data[u] !== 16'h0) begin n_bad++; $display("FAIL reset_read_data u%0d: got %h expected 0000", u, read_data[u]); end
    end
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (resp_valid[0] !== 1'b0 || resp_valid[1] !== 1'b0) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL idle_no_resp: got %0d pulses expected 0", seen); end
  endtask

  task automatic test_write_read();
    int lat, bad, ac;
    logic [15:0] rd;
    logic err;
    do_req(0, 1'b1, 16'h0010, 16'hBEEF, lat, rd, err, bad, ac);
    model_access(0, 1'b1, 16'h0010, 16'hBEEF, 2'b11);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL wr_latency: got %0d expected 3", lat); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL wr_err: got %b expected 0", err); end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL wr_handshake: got %0d glitches expected 0", bad); end
    n_cmp++; if (rd !== last_rd[0]) begin n_bad++; $display("FAIL wr_holds_read_data: got %h expected %h", rd, last_rd[0]); end
    @(negedge clk);
    n_cmp++; if (resp_valid[0] !== 1'b0) begin n_bad++; $display("FAIL resp_one_cycle: got %b expected 0", resp_valid[0]); end
    do_req(0, 1'b0, 16'h0010, 16'h0000, lat, rd, err, bad, ac);
    model_access(0, 1'b0, 16'h0010, 16'h0000, 2'b11);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rd_latency: got %0d expected 3", lat); end
    n_cmp++; if (rd !== 16'hBEEF) begin n_bad++; $display("FAIL rd_data: got %h expected beef", rd); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rd_err: got %b expected 0", err); end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL rd_handshake: got %0d glitches expected 0", bad); end
  endtask

  task automatic test_back_to_back();
    int lat, bad, ac1, ac2;
    logic [15:0] rd1, rd2;
    logic err;
    do_req(1, 1'b1, 16'h0001, 16'h1111, lat, rd1, err, bad, ac1);
    model_access(1, 1'b1, 16'h0001, 16'h1111, 2'b11);
    do_req(1, 1'b1, 16'h0002, 16'h2222, lat, rd1, err, bad, ac1);
    model_access(1, 1'b1, 16'h0002, 16'h2222, 2'b11);
    do_req(1, 1'b0, 16'h0001, 16'h0000, lat, rd1, err, bad, ac1);
    model_access(1, 1'b0, 16'h0001, 16'h0000, 2'b11);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL b2b_lat1: got %0d expected 1", lat); end
    do_req(1, 1'b0, 16'h0002, 16'h0000, lat, rd2, err, bad, ac2);
    model_access(1, 1'b0, 16'h0002, 16'h0000, 2'b11);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL b2b_lat2: got %0d expected 1", lat); end
    n_cmp++; if (ac2 - ac1 !== 2) begin n_bad++; $display("FAIL b2b_spacing: got %0d expected 2", ac2 - ac1); end
    n_cmp++; if (rd1 !== 16'h1111) begin n_bad++; $display("FAIL b2b_data1: got %h expected 1111", rd1); end
    n_cmp++; if (rd2 !== 16'h2222) begin n_bad++; $display("FAIL b2b_data2: got %h expected 2222", rd2); end
  endtask

  task automatic test_out_of_range();
    int lat, bad, ac;
    logic [15:0] rd;
    logic err;
    do_req(0, 1'b1, 16'h0000, 16'h7777, lat, rd, err, bad, ac);
    do_req(0, 1'b1, 16'h0005, 16'h0505, lat, rd, err, bad, ac);
    model_access(0, 1'b1, 16'h0000, 16'h7777, 2'b11);
    model_access(0, 1'b1, 16'h0005, 16'h0505, 2'b11);
    do_req(0, 1'b1, 16'h0100, 16'hDEAD, lat, rd, err, bad, ac);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL oor_wr_err: got %b expected 1", err); end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL oor_wr_lat: got %0d expected 3", lat); end
    do_req(0, 1'b1, 16'hFF05, 16'hDEAD, lat, rd, err, bad, ac);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL oor_alias_err: got %b expected 1", err); end
    do_req(0, 1'b0, 16'h0000, 16'h0000, lat, rd, err, bad, ac);
    n_cmp++; if (rd !== 16'h7777) begin n_bad++; $display("FAIL oor_word0_kept: got %h expected 7777", rd); end
    do_req(0, 1'b0, 16'h0005, 16'h0000, lat, rd, err, bad, ac);
    n_cmp++; if (rd !== 16'h0505) begin n_bad++; $display("FAIL oor_no_alias: got %h expected 0505", rd); end
    do_req(0, 1'b0, 16'h0100, 16'h0000, lat, rd, err, bad, ac);
    model_access(0, 1'b0, 16'h0100, 16'h0000, 2'b11);
    n_cmp++; if (rd !== 16'h0000) begin n_bad++; $display("FAIL oor_rd_data: got %h expected 0000", rd); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL oor_rd_err: got %b expected 1", err); end
  endtask

  task automatic test_reset_mid();
    int lat, bad, ac, seen;
    logic [15:0] rd;
    logic err;
    do_req(0, 1'b1, 16'h0005, 16'hCAFE, lat, rd, err, bad, ac);
    model_access(0, 1'b1, 16'h0005, 16'hCAFE, 2'b11);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; address[0] = 16'h0005; write_data[0] = 16'h1234;
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_rd[0] = 16'h0; last_rd[1] = 16'h0;
    n_cmp++; if (resp_valid[0] !== 1'b0) begin n_bad++; $display("FAIL midrst_resp: got %b expected 0", resp_valid[0]); end
    n_cmp++; if (req_ready[0] !== 1'b1) begin n_bad++; $display("FAIL midrst_ready: got %b expected 1", req_ready[0]); end
    n_cmp++; if (read_data[0] !== 16'h0) begin n_bad++; $display("FAIL midrst_read_data: got %h expected 0000", read_data[0]); end
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid[0] !== 1'b0) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL midrst_late_resp: got %0d pulses expected 0", seen); end
    do_req(0, 1'b0, 16'h0005, 16'h0000, lat, rd, err, bad, ac);
    model_access(0, 1'b0, 16'h0005, 16'h0000, 2'b11);
    n_cmp++; if (rd !== 16'hCAFE) begin n_bad++; $display("FAIL midrst_no_write: got %h expected cafe", rd); end
  endtask

`ifdef DMEM_BYTE_EN_EN
  task automatic test_byte_mask();
    int lat, bad, ac;
    logic [15:0] rd;
    logic err;
    write_mask[0] = 2'b11;
    do_req(0, 1'b1, 16'h0003, 16'hAAAA, lat, rd, err, bad, ac);
    write_mask[0] = 2'b01;
    do_req(0, 1'b1, 16'h0003, 16'h5555, lat, rd, err, bad, ac);
    write_mask[0] = 2'b00;
    do_req(0, 1'b0, 16'h0003, 16'h0000, lat, rd, err, bad, ac);
    n_cmp++; if (rd !== 16'hAA55) begin n_bad++; $display("FAIL mask_low_byte: got %h expected aa55", rd); end
    write_mask[0] = 2'b11;
    do_req(0, 1'b1, 16'h0003, 16'hAAAA, lat, rd, err, bad, ac);
    write_mask[0] = 2'b00;
    do_req(0, 1'b1, 16'h0003, 16'h5555, lat, rd, err, bad, ac);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL mask_zero_resp: got %0d expected 3", lat); end
    write_mask[0] = 2'b11;
    do_req(0, 1'b0, 16'h0003, 16'h0000, lat, rd, err, bad, ac);
    n_cmp++; if (rd !== 16'hAAAA) begin n_bad++; $display("FAIL mask_zero_data: got %h expected aaaa", rd); end
    last_rd[0] = 16'hAAAA;
    ref_mem[0][3] = 16'hAAAA;
  endtask
`endif

  task automatic test_random();
    int lat, bad, ac, u, sel;
    logic [15:0] rd, addr, data;
    logic [1:0] mask;
    logic err;
    bit wr;
    for (int p = 0; p < 2; p++) begin
      for (int a = 0; a < 17; a++) begin
        addr = (a == 16) ? 16'h00FF : 16'(a);
        data = 16'($urandom);
`ifdef DMEM_BYTE_EN_EN
        write_mask[p] = 2'b11;
`endif
        do_req(p, 1'b1, addr, data, lat, rd, err, bad, ac);
        model_access(p, 1'b1, addr, data, 2'b11);
      end
    end
    for (int t = 0; t < 80; t++) begin
      u = int'($urandom_range(0, 1));
      wr = 1'($urandom);
      sel = int'($urandom_range(0, 9));
      if (sel < 7)       addr = 16'($urandom_range(0, 15));
      else if (sel == 7) addr = 16'h00FF;
      else if (sel == 8) addr = 16'h0100 + 16'($urandom_range(0, 255));
      else               addr = 16'hFF00 | 16'($urandom_range(0, 15));
      data = 16'($urandom);
`ifdef DMEM_BYTE_EN_EN
      mask = 2'($urandom);
      write_mask[u] = mask;
`else
      mask = 2'b11;
`endif
      do_req(u, wr, addr, data, lat, rd, err, bad, ac);
      model_access(u, wr, addr, data, mask);
      n_cmp++; if (lat !== wc(u) + 1) begin n_bad++; $display("FAIL rnd_latency t%0d: got %0d expected %0d", t, lat, wc(u) + 1); end
      n_cmp++; if (err !== (addr >= 16'd256)) begin n_bad++; $display("FAIL rnd_err t%0d addr %h: got %b expected %b", t, addr, err, addr >= 16'd256); end
      n_cmp++; if (rd !== last_rd[u]) begin n_bad++; $display("FAIL rnd_read_data t%0d u%0d addr %h: got %h expected %h", t, u, addr, rd, last_rd[u]); end
      n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL rnd_handshake t%0d: got %0d glitches expected 0", t, bad); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid();
`ifdef DMEM_BYTE_EN_EN
    test_byte_mask();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
